// File: rtl/aes_decrypt_iter_pkg.sv
// Shared AES types and GF(2^8) helpers: S-box / inverse S-box computed from the field inverse,
// round constants, forward and inverse single-step key schedule, InvMixColumns on one column.
package aes_decrypt_iter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [127:0] keyschedule(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // rc is the constant that produced k, so the result is the preceding round key
    function automatic logic [127:0] inv_keyschedule(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]   ^ k[63:32];
        w2 = k[63:32]  ^ k[95:64];
        w1 = k[95:64]  ^ k[127:96];
        w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes_decrypt_iter_if.sv
// Job bus of the iterative decryptor: key/ciphertext in with valid/ready, plaintext out with valid/ready.
interface aes_decrypt_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] keyin;
    logic [127:0] statein;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] stateout;
    logic         busy;

    modport master (output in_valid, keyin, statein, out_ready,
                    input  in_ready, out_valid, stateout, busy);
    modport slave  (input  in_valid, keyin, statein, out_ready,
                    output in_ready, out_valid, stateout, busy);
endinterface

// File: rtl/aes_decrypt_iter_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module aes_decrypt_iter_inv_round
    import aes_decrypt_iter_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    input  logic         last_i,
    output logic [127:0] state_o
);
    logic [127:0] sub_v;
    logic [127:0] mix_v;

    // byte i sits at row i%4, column i/4; row r was rotated left by r, so fetch from column c-r
    always_comb begin
        sub_v = '0;
        for (int i = 0; i < 16; i++) begin
            sub_v[127 - 8*i -: 8] =
                inv_sbox(state_i[127 - 8*((i % 4) + 4*(((i / 4) + 4 - (i % 4)) % 4)) -: 8])
                ^ key_i[127 - 8*i -: 8];
        end
    end

    always_comb begin
        mix_v = '0;
        for (int c = 0; c < 4; c++) begin
            mix_v[127 - 32*c -: 32] = inv_mix_col(sub_v[127 - 32*c -: 32]);
        end
    end

    assign state_o = last_i ? sub_v : mix_v;
endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor, one inverse round per clock; 20 cycles accept-to-valid on a key miss, 10 on a hit.
// Single job in flight: in_ready only in IDLE, result held in DONE until out_ready.
module aes_decrypt_iter
    import aes_decrypt_iter_pkg::*;
#(
    parameter bit KEY_CACHE = 1'b1
)(
    input  logic              clk,
    input  logic              rst_n,
    aes_decrypt_iter_if.slave bus
);
    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] key_q, key_d;
    logic [127:0] state_q, state_d;
    logic [127:0] stateout_q, stateout_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] cached_key_q, cached_key_d;
    logic [127:0] k10_q, k10_d;
    logic         cache_vld_q, cache_vld_d;

    logic [127:0] fwd_key;
    logic [127:0] inv_key;
    logic [127:0] round_out;
    logic         cache_hit;

    assign fwd_key   = keyschedule(key_q, rcon(rnd_q));
    assign inv_key   = inv_keyschedule(key_q, rcon(rnd_q));
    assign cache_hit = KEY_CACHE && cache_vld_q && (bus.keyin == cached_key_q);

    aes_decrypt_iter_inv_round u_inv_round (
        .state_i (state_q),
        .key_i   (inv_key),
        .last_i  (rnd_q == 4'd1),
        .state_o (round_out)
    );

    always_comb begin
        fsm_d        = fsm_q;
        rnd_d        = rnd_q;
        key_d        = key_q;
        state_d      = state_q;
        stateout_d   = stateout_q;
        out_valid_d  = out_valid_q;
        cached_key_d = cached_key_q;
        k10_d        = k10_q;
        cache_vld_d  = cache_vld_q;
        case (fsm_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (cache_hit) begin
                        key_d   = k10_q;
                        state_d = bus.statein ^ k10_q;
                        rnd_d   = 4'd10;
                        fsm_d   = ROUND;
                    end else begin
                        // state holds the ciphertext until round key 10 is known
                        key_d        = bus.keyin;
                        state_d      = bus.statein;
                        cached_key_d = bus.keyin;
                        cache_vld_d  = 1'b0;
                        rnd_d        = 4'd1;
                        fsm_d        = EXPAND;
                    end
                end
            end
            EXPAND: begin
                key_d = fwd_key;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'd10) begin
                    state_d     = state_q ^ fwd_key;
                    k10_d       = fwd_key;
                    cache_vld_d = 1'b1;
                    rnd_d       = 4'd10;
                    fsm_d       = ROUND;
                end
            end
            ROUND: begin
                key_d   = inv_key;
                state_d = round_out;
                if (rnd_q == 4'd1) begin
                    stateout_d  = round_out;
                    out_valid_d = 1'b1;
                    fsm_d       = DONE;
                end else begin
                    rnd_d = rnd_q - 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= IDLE;
            rnd_q        <= 4'd0;
            key_q        <= '0;
            state_q      <= '0;
            stateout_q   <= '0;
            out_valid_q  <= 1'b0;
            cached_key_q <= '0;
            k10_q        <= '0;
            cache_vld_q  <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            rnd_q        <= rnd_d;
            key_q        <= key_d;
            state_q      <= state_d;
            stateout_q   <= stateout_d;
            out_valid_q  <= out_valid_d;
            cached_key_q <= cached_key_d;
            k10_q        <= k10_d;
            cache_vld_q  <= cache_vld_d;
        end
    end

    assign bus.in_ready  = (fsm_q == IDLE);
    assign bus.busy      = (fsm_q == EXPAND) || (fsm_q == ROUND);
    assign bus.out_valid = out_valid_q;
    assign bus.stateout  = stateout_q;
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Scoreboard bench: plaintexts come from FIPS vectors or from a byte-level AES encryptor model.
module tb_aes_decrypt_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_decrypt_iter_if bus ();
    aes_decrypt_iter_if bus_nc ();

    aes_decrypt_iter #(.KEY_CACHE(1'b1)) dut    (.clk(clk), .rst_n(rst_n), .bus(bus));
    aes_decrypt_iter #(.KEY_CACHE(1'b0)) dut_nc (.clk(clk), .rst_n(rst_n), .bus(bus_nc));

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [127:0] pt;
        int           acc;
        int           lat;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         cur;
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    logic [7:0]   sbx [256];
    logic [127:0] model_key = '0;
    bit           model_vld = 1'b0;
    bit           rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // walks generator 3 and its inverse through the field to fill the S-box
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ xt(p);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbx[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbx[0] = 8'h63;
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] ct;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbx[tmp[23:16]], sbx[tmp[15:8]], sbx[tmp[7:0]], sbx[tmp[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbx[s[(i % 4) + 4*(((i / 4) + (i % 4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (r == 10) begin
                    for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
                end else begin
                    s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127 - 8*i -: 8] = s[i];
        return ct;
    endfunction

    // called at posedge+1; the key-cache model decides the expected latency
    task automatic issue(input logic [127:0] key, input logic [127:0] ct,
                         input logic [127:0] pt, output int acc);
        int n;
        bit hit;
        n = 0;
        acc = 0;
        while (bus.in_ready !== 1'b1) begin
            @(posedge clk); #1;
            n++;
            if (n > 300) begin
                checks++; errors++;
                $display("FAIL issue_timeout: in_ready never rose (cycle %0d)", cyc);
                return;
            end
        end
        hit = model_vld && (key == model_key);
        model_key = key;
        model_vld = 1'b1;
        bus.keyin = key;
        bus.statein = ct;
        bus.in_valid = 1'b1;
        acc = cyc + 1;
        sb_q.push_back('{pt, acc, hit ? 10 : 20});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.in_ready !== 1'b1) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_queue_empty", 128'(sb_q.size()), 128'd0);
    endtask

    task automatic nc_job(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt);
        int acc, n;
        bus_nc.keyin = key;
        bus_nc.statein = ct;
        bus_nc.in_valid = 1'b1;
        acc = cyc + 1;
        @(posedge clk); #1;
        bus_nc.in_valid = 1'b0;
        n = 0;
        while (bus_nc.out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("nocache_latency", 128'(cyc - acc), 128'd20);
        chk("nocache_plaintext", bus_nc.stateout, pt);
        @(posedge clk); #1;
    endtask

    bit prev_vld = 1'b0;
    bit prev_rdy = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (bus.out_valid === 1'b1 && !prev_vld) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: got %h with no job pending (cycle %0d)", bus.stateout, cyc);
                end else begin
                    cur = sb_q.pop_front();
                    chk("plaintext", bus.stateout, cur.pt);
                    chk("latency", 128'(cyc - cur.acc), 128'(cur.lat));
                end
            end else if (prev_vld && !prev_rdy) begin
                chk("hold_out_valid", 128'(bus.out_valid), 128'd1);
                chk("hold_stateout", bus.stateout, cur.pt);
                chk("hold_in_ready_low", 128'(bus.in_ready), 128'd0);
            end
            prev_vld = (bus.out_valid === 1'b1);
            prev_rdy = (bus.out_ready === 1'b1);
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int acc;
        logic [127:0] key, pt;
        bus.in_valid = 1'b0; bus.keyin = '0; bus.statein = '0; bus.out_ready = 1'b1;
        bus_nc.in_valid = 1'b0; bus_nc.keyin = '0; bus_nc.statein = '0; bus_nc.out_ready = 1'b1;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 128'(bus.out_valid), 128'd0);
        chk("reset_stateout", bus.stateout, 128'd0);
        chk("reset_busy", 128'(bus.busy), 128'd0);
        chk("reset_in_ready", 128'(bus.in_ready), 128'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(K1, C1, P1, acc);
        issue(K2, C2, P2, acc);
        issue(K2, C2, P2, acc);
        drain();

        nc_job(K2, C2, P2);
        nc_job(K2, C2, P2);

        // backpressure with a competing request that must be ignored
        bus.out_ready = 1'b0;
        issue(K1, C1, P1, acc);
        for (int n = 0; n < 40 && bus.out_valid !== 1'b1; n++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid_seen", 128'(bus.out_valid), 128'd1);
        bus.keyin = K2; bus.statein = C2; bus.in_valid = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
        end
        chk("bp_no_second_job", 128'(bus.busy), 128'd0);
        chk("bp_queue_empty", 128'(sb_q.size()), 128'd0);

        // reset while in ROUND; cache must be invalidated
        issue(K2, C2, P2, acc);
        while (cyc < acc + 14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 128'(bus.out_valid), 128'd0);
        chk("midreset_stateout", bus.stateout, 128'd0);
        chk("midreset_busy", 128'(bus.busy), 128'd0);
        chk("midreset_in_ready", 128'(bus.in_ready), 128'd1);
        sb_q.delete();
        model_vld = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(K2, C2, P2, acc);
        issue(K1, C1, P1, acc);
        drain();

        rand_rdy = 1'b1;
        key = {$urandom, $urandom, $urandom, $urandom};
        for (int j = 0; j < 1000; j++) begin
            if ($urandom_range(0, 3) != 0) key = {$urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            issue(key, encrypt(key, pt), pt, acc);
        end
        drain();
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        bus.out_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
